traffic_intersection_model: RTL and testbench

- Intersection-side counterpart of the traffic light controller.
- Consumes the controller's two light codes (la, lb) and per-street car-arrival pulses.
- Keeps a saturating car queue per street, releases cars while that street's light is GREEN, and drives the ta/tb traffic sensors back to the controller.
- Contains a sticky safety monitor that flags conflicting, illegal or out-of-sequence light codes. Used as bench stimulus/checker and as a synthesizable demo peripheral.

---
 rtl/traffic_pkg.sv | 27 ++
 rtl/traffic_queue.sv | 84 ++++++++
 rtl/traffic_intersection_model.sv | 94 +++++++++
 tb/tb_traffic_intersection_model.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light controller and the intersection model:
// light encodings, monitor flag positions and the per-street sequencing rule.
package traffic_pkg;

  localparam logic [1:0] GREEN   = 2'b00;
  localparam logic [1:0] YELLOW  = 2'b01;
  localparam logic [1:0] RED     = 2'b10;
  localparam logic [1:0] ILLEGAL = 2'b11;

  localparam int ERR_CONFLICT = 0;
  localparam int ERR_CODE     = 1;
  localparam int ERR_SEQ      = 2;

  // True when a single street jumps out of the G->Y->R->G order.
  // Callers only use it with two legal codes.
  function automatic logic bad_step(input logic [1:0] prev, input logic [1:0] cur);
    logic r;
    case (prev)
      GREEN:   r = (cur == RED);
      YELLOW:  r = (cur == GREEN);
      RED:     r = (cur == YELLOW);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/traffic_queue.sv
// One street of the intersection: saturating car queue, GREEN-timed departures,
// sticky overflow flag and a registered traffic-present sensor.
module traffic_queue
  import traffic_pkg::*;
#(
  parameter int QW            = 4,
  parameter int DEPART_CYCLES = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          arrival,
  input  logic [1:0]    light,
  output logic [QW-1:0] count,
  output logic          depart,
  output logic          ovf,
  output logic          present
);

  localparam logic [QW-1:0] Q_ZERO = {QW{1'b0}};
  localparam logic [QW-1:0] Q_ONE  = QW'(1);
  localparam logic [QW-1:0] Q_MAX  = {QW{1'b1}};
  localparam logic [3:0]    D_LAST = 4'(DEPART_CYCLES - 1);

  logic [3:0]    dcnt_r;
  logic [3:0]    dcnt_s;
  logic [QW-1:0] count_r;
  logic [QW-1:0] count_s;
  logic          ovf_r;
  logic          ovf_s;
  logic          present_r;
  logic          present_s;
  logic          busy_s;
  logic          depart_s;

  // Departure timing runs only while GREEN with a car waiting.
  always_comb begin
    busy_s   = (light == GREEN) && (count_r != Q_ZERO);
    depart_s = busy_s && (dcnt_r == D_LAST);
  end

  // Next departure counter, queue count, overflow and sensor values.
  always_comb begin
    count_s = count_r;
    ovf_s   = ovf_r;
    if (busy_s && !depart_s) begin
      dcnt_s = dcnt_r + 4'd1;
    end else begin
      dcnt_s = 4'd0;
    end
    case ({arrival, depart_s})
      2'b10: begin
        if (count_r == Q_MAX) begin
          ovf_s = 1'b1;
        end else begin
          count_s = count_r + Q_ONE;
        end
      end
      2'b01:   count_s = count_r - Q_ONE;
      default: count_s = count_r;
    endcase
    present_s = (count_s != Q_ZERO);
  end

  // Queue state registers; reset discards every car and the overflow flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dcnt_r    <= 4'd0;
      count_r   <= Q_ZERO;
      ovf_r     <= 1'b0;
      present_r <= 1'b0;
    end else begin
      dcnt_r    <= dcnt_s;
      count_r   <= count_s;
      ovf_r     <= ovf_s;
      present_r <= present_s;
    end
  end

  assign count   = count_r;
  assign depart  = depart_s;
  assign ovf     = ovf_r;
  assign present = present_r;

endmodule

// File: rtl/traffic_intersection_model.sv
// Intersection side of the traffic light system: two street queues fed by
// arrival pulses and released by the controller's lights, plus a sticky
// monitor for conflicting, illegal and out-of-sequence light codes.
module traffic_intersection_model
  import traffic_pkg::*;
#(
  parameter int QW            = 4,
  parameter int DEPART_CYCLES = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          arr_a,
  input  logic          arr_b,
  input  logic [1:0]    la,
  input  logic [1:0]    lb,
  output logic          ta,
  output logic          tb,
  output logic [QW-1:0] qa,
  output logic [QW-1:0] qb,
  output logic          dep_a,
  output logic          dep_b,
  output logic          ovf_a,
  output logic          ovf_b,
  output logic [2:0]    err_code,
  output logic          err
);

  logic [1:0] prev_la_r;
  logic [1:0] prev_lb_r;
  logic       prev_valid_r;
  logic [2:0] err_code_r;
  logic [2:0] err_code_s;
  logic [2:0] flags_s;
  logic       err_r;
  logic       err_s;

  traffic_queue #(.QW(QW), .DEPART_CYCLES(DEPART_CYCLES)) u_queue_a (
    .clock   (clock),
    .reset   (reset),
    .arrival (arr_a),
    .light   (la),
    .count   (qa),
    .depart  (dep_a),
    .ovf     (ovf_a),
    .present (ta)
  );

  traffic_queue #(.QW(QW), .DEPART_CYCLES(DEPART_CYCLES)) u_queue_b (
    .clock   (clock),
    .reset   (reset),
    .arrival (arr_b),
    .light   (lb),
    .count   (qb),
    .depart  (dep_b),
    .ovf     (ovf_b),
    .present (tb)
  );

  // Classify the current light sample and accumulate sticky flags.
  always_comb begin
    flags_s               = 3'b000;
    flags_s[ERR_CONFLICT] = (la != RED) && (lb != RED);
    flags_s[ERR_CODE]     = (la == ILLEGAL) || (lb == ILLEGAL);
    if (prev_valid_r && (la != ILLEGAL) && (lb != ILLEGAL) &&
        (prev_la_r != ILLEGAL) && (prev_lb_r != ILLEGAL)) begin
      flags_s[ERR_SEQ] = bad_step(prev_la_r, la) || bad_step(prev_lb_r, lb);
    end else begin
      flags_s[ERR_SEQ] = 1'b0;
    end
    err_code_s = err_code_r | flags_s;
    err_s      = |err_code_s;
  end

  // Monitor registers: previous codes, history-valid bit and sticky flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_la_r    <= RED;
      prev_lb_r    <= RED;
      prev_valid_r <= 1'b0;
      err_code_r   <= 3'b000;
      err_r        <= 1'b0;
    end else begin
      prev_la_r    <= la;
      prev_lb_r    <= lb;
      prev_valid_r <= 1'b1;
      err_code_r   <= err_code_s;
      err_r        <= err_s;
    end
  end

  assign err_code = err_code_r;
  assign err      = err_r;

endmodule

// File: tb/tb_traffic_intersection_model.sv
// Bench for traffic_intersection_model: table-driven scenarios, hand-written
// corner sequences and randomized traffic, all compared with a queue-level model.
module tb_traffic_intersection_model;

  localparam int QW   = 4;
  localparam int D    = 2;
  localparam int QMAX = 15;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       arr_a = 1'b0;
  logic       arr_b = 1'b0;
  logic [1:0] la    = 2'b10;
  logic [1:0] lb    = 2'b10;
  logic       ta, tb, dep_a, dep_b, ovf_a, ovf_b, err;
  logic [QW-1:0] qa, qb;
  logic [2:0] err_code;

  traffic_intersection_model #(.QW(QW), .DEPART_CYCLES(D)) dut (
    .clock(clock), .reset(reset), .arr_a(arr_a), .arr_b(arr_b),
    .la(la), .lb(lb), .ta(ta), .tb(tb), .qa(qa), .qb(qb),
    .dep_a(dep_a), .dep_b(dep_b), .ovf_a(ovf_a), .ovf_b(ovf_b),
    .err_code(err_code), .err(err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: cars waiting, consecutive green-with-cars cycles, flags.
  int       mq[2];
  int       mg[2];
  bit       movf[2];
  bit [2:0] merr;
  int       mprev[2];
  bit       mpv;

  typedef struct {
    bit         rst;
    bit         aa;
    bit         ab;
    logic [1:0] la;
    logic [1:0] lb;
    bit         da;
    bit         db;
    int         qa;
    int         qb;
    logic [2:0] ec;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Light codes as positions on the cycle G(0) -> Y(1) -> R(2) -> G.
  function automatic bit seq_ok(input int p, input int c);
    return (c == p) || (c == (p + 1) % 3);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      mq[s] = 0; mg[s] = 0; movf[s] = 1'b0; mprev[s] = 2;
    end
    merr = 3'b000;
    mpv  = 1'b0;
  endtask

  task automatic check_outputs();
    chk("qa", int'(qa), mq[0]);
    chk("qb", int'(qb), mq[1]);
    chk("ta", int'(ta), int'(mq[0] != 0));
    chk("tb", int'(tb), int'(mq[1] != 0));
    chk("ovf_a", int'(ovf_a), int'(movf[0]));
    chk("ovf_b", int'(ovf_b), int'(movf[1]));
    chk("err_code", int'(err_code), int'(merr));
    chk("err", int'(err), int'(merr != 3'b000));
  endtask

  // Drive one cycle, check departures before the edge and state after it.
  task automatic cycle(input bit aa, input bit ab, input logic [1:0] a,
                       input logic [1:0] b, output bit da, output bit db);
    int       l[2];
    bit       arr[2];
    bit       pdep[2];
    bit [2:0] f;
    arr_a = aa; arr_b = ab; la = a; lb = b;
    l[0] = int'(a); l[1] = int'(b); arr[0] = aa; arr[1] = ab;
    for (int s = 0; s < 2; s++)
      pdep[s] = (l[s] == 0) && (mq[s] > 0) && (mg[s] == D - 1);
    #1;
    da = dep_a; db = dep_b;
    chk("dep_a", int'(dep_a), int'(pdep[0]));
    chk("dep_b", int'(dep_b), int'(pdep[1]));
    @(posedge clock);
    for (int s = 0; s < 2; s++) begin
      if (l[s] == 0 && mq[s] > 0) mg[s] = pdep[s] ? 0 : mg[s] + 1;
      else mg[s] = 0;
      if (arr[s] && !pdep[s]) begin
        if (mq[s] == QMAX) movf[s] = 1'b1;
        else mq[s] = mq[s] + 1;
      end else if (!arr[s] && pdep[s]) begin
        mq[s] = mq[s] - 1;
      end
    end
    f    = 3'b000;
    f[0] = (l[0] != 2) && (l[1] != 2);
    f[1] = (l[0] == 3) || (l[1] == 3);
    if (mpv && l[0] < 3 && l[1] < 3 && mprev[0] < 3 && mprev[1] < 3)
      f[2] = !seq_ok(mprev[0], l[0]) || !seq_ok(mprev[1], l[1]);
    merr = merr | f;
    mprev[0] = l[0]; mprev[1] = l[1];
    mpv = 1'b1;
    #1;
    check_outputs();
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  function automatic vec_t mk(input bit rst, input bit aa, input bit ab,
                              input logic [1:0] a, input logic [1:0] b,
                              input bit da, input bit db, input int eqa,
                              input int eqb, input logic [2:0] ec);
    vec_t v;
    v.rst = rst; v.aa = aa; v.ab = ab; v.la = a; v.lb = b;
    v.da = da; v.db = db; v.qa = eqa; v.qb = eqb; v.ec = ec;
    return v;
  endfunction

  initial begin
    bit         da, db;
    int         phase;
    logic [1:0] ra, rb;
    bit         xa, xb;

    // Queue and release on A (GREEN departures on cycles 2, 4, 6).
    tbl.push_back(mk(1, 1, 0, 2'b10, 2'b00, 0, 0, 1, 0, 3'b000));
    tbl.push_back(mk(0, 1, 0, 2'b10, 2'b00, 0, 0, 2, 0, 3'b000));
    tbl.push_back(mk(0, 1, 0, 2'b10, 2'b00, 0, 0, 3, 0, 3'b000));
    tbl.push_back(mk(0, 0, 0, 2'b10, 2'b01, 0, 0, 3, 0, 3'b000));
    tbl.push_back(mk(0, 0, 0, 2'b10, 2'b10, 0, 0, 3, 0, 3'b000));
    tbl.push_back(mk(0, 0, 0, 2'b00, 2'b10, 0, 0, 3, 0, 3'b000));
    tbl.push_back(mk(0, 0, 0, 2'b00, 2'b10, 1, 0, 2, 0, 3'b000));
    tbl.push_back(mk(0, 0, 0, 2'b00, 2'b10, 0, 0, 2, 0, 3'b000));
    tbl.push_back(mk(0, 0, 0, 2'b00, 2'b10, 1, 0, 1, 0, 3'b000));
    tbl.push_back(mk(0, 0, 0, 2'b00, 2'b10, 0, 0, 1, 0, 3'b000));
    tbl.push_back(mk(0, 0, 0, 2'b00, 2'b10, 1, 0, 0, 0, 3'b000));
    tbl.push_back(mk(0, 0, 0, 2'b00, 2'b10, 0, 0, 0, 0, 3'b000));
    // Yellow aborts a partially timed departure.
    tbl.push_back(mk(0, 1, 0, 2'b00, 2'b10, 0, 0, 1, 0, 3'b000));
    tbl.push_back(mk(0, 0, 0, 2'b00, 2'b10, 0, 0, 1, 0, 3'b000));
    tbl.push_back(mk(0, 0, 0, 2'b01, 2'b10, 0, 0, 1, 0, 3'b000));
    tbl.push_back(mk(0, 0, 0, 2'b10, 2'b10, 0, 0, 1, 0, 3'b000));
    tbl.push_back(mk(0, 0, 0, 2'b00, 2'b10, 0, 0, 1, 0, 3'b000));
    tbl.push_back(mk(0, 0, 0, 2'b00, 2'b10, 1, 0, 0, 0, 3'b000));
    // Monitor: conflict, then illegal code; after reset, G->R directly.
    tbl.push_back(mk(1, 0, 0, 2'b00, 2'b01, 0, 0, 0, 0, 3'b001));
    tbl.push_back(mk(0, 0, 0, 2'b11, 2'b01, 0, 0, 0, 0, 3'b011));
    tbl.push_back(mk(1, 0, 0, 2'b00, 2'b10, 0, 0, 0, 0, 3'b000));
    tbl.push_back(mk(0, 0, 0, 2'b10, 2'b10, 0, 0, 0, 0, 3'b100));

    // Reset and idle.
    model_reset();
    la = 2'b10; lb = 2'b00;
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 2'b10, 2'b00, da, db);

    // Table-driven scenarios.
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      cycle(tbl[i].aa, tbl[i].ab, tbl[i].la, tbl[i].lb, da, db);
      chk($sformatf("tbl%0d_dep_a", i), int'(da), int'(tbl[i].da));
      chk($sformatf("tbl%0d_dep_b", i), int'(db), int'(tbl[i].db));
      chk($sformatf("tbl%0d_qa", i), int'(qa), tbl[i].qa);
      chk($sformatf("tbl%0d_qb", i), int'(qb), tbl[i].qb);
      chk($sformatf("tbl%0d_ta", i), int'(ta), int'(tbl[i].qa != 0));
      chk($sformatf("tbl%0d_err_code", i), int'(err_code), int'(tbl[i].ec));
      chk($sformatf("tbl%0d_err", i), int'(err), int'(tbl[i].ec != 3'b000));
    end

    // Saturation on B, then arrival and departure in the same cycle.
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 2'b10, 2'b10, da, db);
    chk("sat_qb", int'(qb), 15);
    chk("sat_ovf_b", int'(ovf_b), 1);
    cycle(1'b0, 1'b1, 2'b10, 2'b00, da, db);
    cycle(1'b0, 1'b1, 2'b10, 2'b00, da, db);
    chk("sat_dep_b", int'(db), 1);
    chk("sat_hold_qb", int'(qb), 15);

    // Asynchronous reset between edges with qa=5 and err=1.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 2'b10, 2'b10, da, db);
    cycle(1'b0, 1'b0, 2'b11, 2'b10, da, db);
    chk("pre_rst_qa", int'(qa), 5);
    chk("pre_rst_err", int'(err), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_qa", int'(qa), 0);
    chk("async_ta", int'(ta), 0);
    chk("async_err", int'(err), 0);
    chk("async_err_code", int'(err_code), 0);
    do_reset();

    // Randomized traffic: even segments follow a legal controller, odd ones
    // drive arbitrary codes; the last segment floods arrivals.
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      phase = 0;
      ra = 2'b00; rb = 2'b10;
      for (int i = 0; i < 150; i++) begin
        if (seg % 2 == 0) begin
          if ($urandom_range(0, 5) == 0) phase = (phase + 1) % 4;
          case (phase)
            0:       begin ra = 2'b00; rb = 2'b10; end
            1:       begin ra = 2'b01; rb = 2'b10; end
            2:       begin ra = 2'b10; rb = 2'b00; end
            default: begin ra = 2'b10; rb = 2'b01; end
          endcase
        end else if ($urandom_range(0, 3) == 0) begin
          ra = 2'($urandom_range(0, 3));
          rb = 2'($urandom_range(0, 3));
        end
        xa = ($urandom_range(0, 3) < ((seg == 3) ? 3 : 1));
        xb = ($urandom_range(0, 3) < ((seg == 3) ? 3 : 1));
        cycle(xa, xb, ra, rb, da, db);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
